// File: rtl/uart_instr_loader.sv
// uart_instr_loader
//   Parses framed load packets from the UART receive byte stream and writes
//   the packed instruction words into the instruction RAM of tiny_fsm_control.
//   Frame: 0xA5, ADDR, COUNT, COUNT*(INSTR_WIDTH/8) payload bytes (MSB first),
//   CSUM = XOR of ADDR, COUNT and all payload bytes. Each frame is answered
//   with one byte, 0x06 (ACK) or 0x15 (NAK).
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_data/rx_valid   received byte with 1-cycle strobe
//   tx_data/tx_valid   response byte; held until tx_ready
//   tx_ready           transmitter accept
//   wr_en/wr_addr/wr_data  instruction RAM write port (1-cycle strobe)
//   load_busy          a frame is in progress (FSM must not step/run)
//   load_done          pulses on the cycle the response byte is accepted
//   load_error         last frame was NAKed; cleared by the next 0xA5
//   words_loaded       words written by the current/last frame
//
// Handshake: the response byte transfers on every cycle where tx_valid and
// tx_ready are both high; tx_data is stable while tx_valid waits for tx_ready.
// The FSM state is held in state_q (type state_t) for hierarchical probing.
module uart_instr_loader #(
  parameter int INSTR_WIDTH    = 32,
  parameter int INSTR_DEPTH    = 256,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           wr_en,
  output logic [$clog2(INSTR_DEPTH)-1:0] wr_addr,
  output logic [INSTR_WIDTH-1:0]         wr_data,
  output logic                           load_busy,
  output logic                           load_done,
  output logic                           load_error,
  output logic [$clog2(INSTR_DEPTH):0]   words_loaded
);

  localparam int AW  = $clog2(INSTR_DEPTH);
  localparam int BPW = INSTR_WIDTH / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CSUM, S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;         // address of the next word
  logic [7:0]             count_q, count_d;
  logic [7:0]             word_cnt_q, word_cnt_d;
  logic [BW-1:0]          byte_idx_q, byte_idx_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [7:0]             csum_q, csum_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   wr_en_q, wr_en_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   load_error_q, load_error_d;
  logic [AW:0]            words_loaded_q, words_loaded_d;

  logic                   mid_frame;
  logic [INSTR_WIDTH-1:0] word_next;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    count_d        = count_q;
    word_cnt_d     = word_cnt_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    csum_d         = csum_q;
    timer_d        = timer_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    load_error_d   = load_error_q;
    words_loaded_d = words_loaded_q;

    mid_frame = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
    word_next = (word_q << 8) | INSTR_WIDTH'(rx_data);

    // Idle timer: any received byte restarts the count.
    if (mid_frame) begin
      timer_d = rx_valid ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HDR) begin
          state_d        = S_ADDR;
          load_error_d   = 1'b0;
          words_loaded_d = '0;
          csum_d         = '0;
          timer_d        = '0;
          word_cnt_d     = '0;
          byte_idx_d     = '0;
          word_d         = '0;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          ptr_d   = rx_data[AW-1:0];
          csum_d  = csum_q ^ rx_data;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_valid) begin
          count_d = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = (rx_data == 8'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          word_d = word_next;
          if (byte_idx_q == BW'(BPW - 1)) begin
            // Word complete: the registered write strobe appears next cycle.
            byte_idx_d     = '0;
            wr_en_d        = 1'b1;
            wr_addr_d      = ptr_q;
            wr_data_d      = word_next;
            ptr_d          = (ptr_q == AW'(INSTR_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            words_loaded_d = words_loaded_q + 1'b1;
            word_cnt_d     = word_cnt_q + 8'd1;
            if ((word_cnt_q + 8'd1) == count_q) begin
              state_d = S_CSUM;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
          if (rx_data == csum_q) begin
            tx_data_d = ACK;
          end else begin
            tx_data_d    = NAK;
            load_error_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        // Incoming bytes are dropped here, even on the handshake cycle.
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Silent link mid-frame: abort and NAK; any partial word is discarded.
    if (mid_frame && !rx_valid && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d      = S_RESP;
      tx_valid_d   = 1'b1;
      tx_data_d    = NAK;
      load_error_d = 1'b1;
      word_d       = '0;
      byte_idx_d   = '0;
      timer_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      count_q        <= '0;
      word_cnt_q     <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      csum_q         <= '0;
      timer_q        <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      load_error_q   <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      count_q        <= count_d;
      word_cnt_q     <= word_cnt_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      timer_q        <= timer_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      load_error_q   <= load_error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign load_busy    = (state_q != S_IDLE);
  // tx_valid is only ever high in RESP, so this marks the accept cycle.
  assign load_done    = tx_valid_q & tx_ready;
  assign load_error   = load_error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
module tb_uart_instr_loader;

  localparam int W  = 32;
  localparam int D  = 256;
  localparam int TO = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [W-1:0] wr_data;
  logic       load_busy;
  logic       load_done;
  logic       load_error;
  logic [8:0] words_loaded;

  always #5 clk = ~clk;

  uart_instr_loader #(
    .INSTR_WIDTH(W), .INSTR_DEPTH(D), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int wr_seen = 0;
  int done_seen = 0;
  logic [39:0] exp_q[$];    // {addr, data} of expected RAM writes
  logic [7:0]  exp_tx_q[$]; // expected response bytes

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change just after rising edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) check("wr_unexpected", {24'd1, wr_addr, wr_data}, 64'd0);
        else check("wr_addr_data", {24'd0, wr_addr, wr_data}, {24'd0, exp_q.pop_front()});
      end
      if (tx_valid && tx_ready) begin
        done_seen++;
        check("load_done_on_accept", 64'(load_done), 64'd1);
        if (exp_tx_q.size() == 0) check("tx_unexpected", {56'd1, tx_data}, 64'd0);
        else check("tx_byte", 64'(tx_data), 64'(exp_tx_q.pop_front()));
      end else if (load_done) begin
        check("load_done_spurious", 64'(load_done), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cnt,
                            input logic [63:0] pl, input logic [7:0] csum,
                            input bit hdr_chk);
    send_byte(8'hA5);
    if (hdr_chk) check("hdr_clears_error", 64'(load_error), 64'd0);
    send_byte(addr);
    send_byte(cnt);
    for (int i = 0; i < int'(cnt) * 4; i++) send_byte(pl[63 - 8*i -: 8]);
    send_byte(csum);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      step();
      if (!load_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cnt;
    logic [63:0] pl;
    logic [7:0]  csum;
    logic [7:0]  exp_tx;
    logic        exp_err;
    int          exp_words;
    logic [39:0] w0;
    logic [39:0] w1;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit stable;

    vecs[0] = '{8'h00, 8'h02, 64'hDEADBEEF_01020304, 8'h24, 8'h06, 1'b0, 2,
                {8'h00, 32'hDEADBEEF}, {8'h01, 32'h01020304}};
    vecs[1] = '{8'h00, 8'h02, 64'hDEADBEEF_01020304, 8'h25, 8'h15, 1'b1, 2,
                {8'h00, 32'hDEADBEEF}, {8'h01, 32'h01020304}};
    vecs[2] = '{8'hFF, 8'h02, 64'h11223344_55667788, 8'h75, 8'h06, 1'b0, 2,
                {8'hFF, 32'h11223344}, {8'h00, 32'h55667788}};
    vecs[3] = '{8'h07, 8'h00, 64'd0, 8'h07, 8'h06, 1'b0, 0, 40'd0, 40'd0};

    // Reset state
    step();
    step();
    check("rst_flags", {59'd0, wr_en, tx_valid, load_busy, load_done, load_error}, 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    rst_n = 1'b1;
    step();

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].exp_words > 0) exp_q.push_back(vecs[v].w0);
      if (vecs[v].exp_words > 1) exp_q.push_back(vecs[v].w1);
      exp_tx_q.push_back(vecs[v].exp_tx);
      if (v == 3) begin
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_ignored", 64'(load_busy), 64'd0);
      end
      send_frame(vecs[v].addr, vecs[v].cnt, vecs[v].pl, vecs[v].csum, v == 2);
      wait_idle($sformatf("v%0d_idle", v), 20);
      check($sformatf("v%0d_error", v), 64'(load_error), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_words", v), 64'(words_loaded), 64'(vecs[v].exp_words));
    end

    // Timeout mid-word: no write, NAK, error
    exp_tx_q.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'hAA);
    wait_idle("timeout_idle", TO + 50);
    check("timeout_error", 64'(load_error), 64'd1);
    check("timeout_words", 64'(words_loaded), 64'd0);

    // Response held off by tx_ready
    tx_ready = 1'b0;
    exp_q.push_back({8'h40, 32'hCAFEF00D});
    exp_tx_q.push_back(8'h06);
    send_frame(8'h40, 8'h01, {32'hCAFEF00D, 32'd0}, 8'h88, 1'b0);
    check("hold_tx_valid", 64'(tx_valid), 64'd1);
    check("hold_tx_data", 64'(tx_data), 64'h06);
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!(tx_valid && tx_data == 8'h06 && !load_done && load_busy)) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    tx_ready = 1'b1;
    wait_idle("hold_idle", 5);
    check("hold_error", 64'(load_error), 64'd0);

    // Reset mid-DATA
    exp_q.push_back({8'h20, 32'h01020304});
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h02);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    check("pre_rst_words", 64'(words_loaded), 64'd1);
    check("pre_rst_busy", 64'(load_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {59'd0, wr_en, tx_valid, load_busy, load_done, load_error}, 64'd0);
    check("midrst_data", {15'd0, words_loaded, tx_data, wr_addr, wr_data}, 64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("post_rst_idle", {61'd0, wr_en, tx_valid, load_busy}, 64'd0);

    // Totals
    check("writes_total", 64'(wr_seen), 64'd8);
    check("done_total", 64'(done_seen), 64'd6);
    check("exp_wr_drained", 64'(exp_q.size()), 64'd0);
    check("exp_tx_drained", 64'(exp_tx_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
